// File: rtl/countdown_timer_if.sv
//------------------------------------------------------------------------------
// countdown_timer_if : load handshake, control and status bundle of the timer.
// The reload line exists only when COUNTDOWN_AUTO_RELOAD_EN is defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface countdown_timer_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             abort;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic             reload;
`endif
  logic [WIDTH-1:0] count_out;
  logic             busy;
  logic             expired;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  modport master (
    output load_valid, load_value, enable, abort, reload,
    input  load_ready, count_out, busy, expired
  );
  modport slave (
    input  load_valid, load_value, enable, abort, reload,
    output load_ready, count_out, busy, expired
  );
`else
  modport master (
    output load_valid, load_value, enable, abort,
    input  load_ready, count_out, busy, expired
  );
  modport slave (
    input  load_valid, load_value, enable, abort,
    output load_ready, count_out, busy, expired
  );
`endif
endinterface

`default_nettype wire

// File: rtl/countdown_timer.sv
//------------------------------------------------------------------------------
// countdown_timer : loadable down-counter with IDLE/RUN/DONE control, pause,
// abort and a one-cycle expired pulse. Optional auto-reload via the macro
// COUNTDOWN_AUTO_RELOAD_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  countdown_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_expired;
  logic             r_busy;
  logic             r_load_ready;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload;
`endif

  logic w_handshake;
  logic w_reload_req;

  assign w_handshake = bus.load_valid && r_load_ready && !bus.abort;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  assign w_reload_req = bus.reload;
`else
  assign w_reload_req = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_expired    <= 1'b0;
      r_busy       <= 1'b0;
      r_load_ready <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      r_reload     <= '0;
`endif
    end else begin
      r_expired <= 1'b0;
      if (bus.abort) begin
        // Abort beats load and terminal count alike, so it never pulses.
        r_state      <= IDLE;
        r_count      <= '0;
        r_busy       <= 1'b0;
        r_load_ready <= 1'b1;
      end else begin
        case (r_state)
          IDLE, DONE: begin
            if (w_handshake) begin
              r_count <= bus.load_value;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              r_reload <= bus.load_value;
`endif
              if (bus.load_value != '0) begin
                r_state      <= RUN;
                r_busy       <= 1'b1;
                r_load_ready <= 1'b0;
              end else begin
                r_state      <= DONE;
                r_expired    <= 1'b1;
                r_busy       <= 1'b0;
                r_load_ready <= 1'b1;
              end
            end
          end
          RUN: begin
            if (bus.enable) begin
              if (r_count > c_one) begin
                r_count <= r_count - c_one;
              end else if (r_count == c_one) begin
                r_expired <= 1'b1;
                if (w_reload_req) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                  r_count <= r_reload;
`endif
                end else begin
                  r_count      <= '0;
                  r_state      <= DONE;
                  r_busy       <= 1'b0;
                  r_load_ready <= 1'b1;
                end
              end else begin
                // A zero count in RUN is unreachable; park safely without a pulse.
                r_state      <= DONE;
                r_busy       <= 1'b0;
                r_load_ready <= 1'b1;
              end
            end
          end
          default: begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_busy       <= 1'b0;
            r_load_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.count_out  = r_count;
  assign bus.expired    = r_expired;
  assign bus.busy       = r_busy;
  assign bus.load_ready = r_load_ready;

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
//------------------------------------------------------------------------------
// tb_countdown_timer : directed bench with a cycle-level reference model and a
// per-cycle comparator, plus literal expectations for the key sequences.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_countdown_timer;

  localparam int WIDTH = 4;

  logic clock;
  logic reset;

  countdown_timer_if #(.WIDTH(WIDTH)) cif ();

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (cif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests;
  int n_fail;
  int exp_seen;
  bit chk_en;

  // Reference model: a count, a running flag and the pulse due this cycle.
  int m_count;
  bit m_running;
  bit m_exp;
  int m_reload;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_count   = 0;
      m_running = 0;
      m_exp     = 0;
      m_reload  = 0;
    end else begin
      m_exp = 0;
      if (cif.abort) begin
        m_count   = 0;
        m_running = 0;
      end else if (!m_running) begin
        if (cif.load_valid) begin
          m_count   = int'(cif.load_value);
          m_reload  = m_count;
          m_running = (m_count != 0);
          m_exp     = (m_count == 0);
        end
      end else if (cif.enable) begin
        if (m_count == 1) begin
          m_exp = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          if (cif.reload) m_count = m_reload;
          else begin m_count = 0; m_running = 0; end
`else
          m_count   = 0;
          m_running = 0;
`endif
        end else begin
          m_count = m_count - 1;
        end
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("model count_out", int'(cif.count_out), m_count);
      check("model busy", int'(cif.busy), int'(m_running));
      check("model load_ready", int'(cif.load_ready), int'(!m_running));
      check("model expired", int'(cif.expired), int'(m_exp));
      if (cif.expired === 1'b1) exp_seen++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic outs(input string name, input int cnt, input int bsy, input int rdy, input int ex);
    check({name, " count"}, int'(cif.count_out), cnt);
    check({name, " busy"}, int'(cif.busy), bsy);
    check({name, " ready"}, int'(cif.load_ready), rdy);
    check({name, " expired"}, int'(cif.expired), ex);
  endtask

  initial begin
    int e0;
    n_tests = 0; n_fail = 0; exp_seen = 0; chk_en = 0;
    reset = 1'b1;
    cif.load_valid = 0; cif.load_value = '0; cif.enable = 0; cif.abort = 0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    cif.reload = 0;
`endif
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    chk_en = 1;
    outs("reset", 0, 0, 1, 0);

    // Load 3, run to zero.
    cif.load_valid = 1; cif.load_value = 4'd3; cif.enable = 1;
    tick(); cif.load_valid = 0;
    outs("l3 c3", 3, 1, 0, 0);
    tick(); outs("l3 c2", 2, 1, 0, 0);
    tick(); outs("l3 c1", 1, 1, 0, 0);
    tick(); outs("l3 c0", 0, 0, 1, 1);
    tick(); outs("l3 done hold", 0, 0, 1, 0);

    // Load 6, pause at 4 for three cycles.
    e0 = exp_seen;
    cif.load_valid = 1; cif.load_value = 4'd6;
    tick(); cif.load_valid = 0;
    outs("l6 c6", 6, 1, 0, 0);
    tick(); tick(); outs("l6 c4", 4, 1, 0, 0);
    cif.enable = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); outs("l6 pause", 4, 1, 0, 0);
    end
    cif.enable = 1;
    tick(); outs("l6 c3", 3, 1, 0, 0);
    tick(); tick(); outs("l6 c1", 1, 1, 0, 0);
    tick(); outs("l6 c0", 0, 0, 1, 1);
    tick();
    check("l6 one pulse", exp_seen - e0, 1);

    // Load 9, abort with a simultaneous load at count 5.
    e0 = exp_seen;
    cif.load_valid = 1; cif.load_value = 4'd9;
    tick(); cif.load_valid = 0;
    repeat (4) tick();
    outs("l9 c5", 5, 1, 0, 0);
    cif.abort = 1; cif.load_valid = 1; cif.load_value = 4'd3;
    tick(); cif.abort = 0; cif.load_valid = 0;
    outs("abort", 0, 0, 1, 0);
    tick(); outs("abort after", 0, 0, 1, 0);
    check("abort no pulse", exp_seen - e0, 0);

    // Abort exactly at terminal count suppresses the pulse.
    cif.load_valid = 1; cif.load_value = 4'd1;
    tick(); cif.load_valid = 0;
    outs("l1", 1, 1, 0, 0);
    cif.abort = 1;
    tick(); cif.abort = 0;
    outs("abort term", 0, 0, 1, 0);
    tick(); outs("abort term after", 0, 0, 1, 0);

    // load_valid during RUN is ignored.
    cif.load_valid = 1; cif.load_value = 4'd5;
    tick(); cif.load_value = 4'd2;
    outs("l5", 5, 1, 0, 0);
    tick(); cif.load_valid = 0;
    outs("run ignores load", 4, 1, 0, 0);
    cif.abort = 1; tick(); cif.abort = 0;

    // Load 0 from IDLE.
    e0 = exp_seen;
    cif.load_valid = 1; cif.load_value = 4'd0;
    tick(); cif.load_valid = 0;
    outs("l0", 0, 0, 1, 1);
    tick(); outs("l0 after", 0, 0, 1, 0);
    check("l0 one pulse", exp_seen - e0, 1);

    // Load 7, async reset mid-cycle at count 4.
    cif.load_valid = 1; cif.load_value = 4'd7;
    tick(); cif.load_valid = 0;
    repeat (3) tick();
    outs("l7 c4", 4, 1, 0, 0);
    #1 reset = 1'b1;
    #1 outs("async reset", 0, 0, 1, 0);
    cif.load_valid = 1; cif.load_value = 4'd9;
    tick(); outs("reset ignores load", 0, 0, 1, 0);
    cif.load_valid = 0;
    reset = 1'b0;
    tick(); outs("post reset", 0, 0, 1, 0);

    // Full-scale load and a mixed vector sweep checked by the model.
    cif.load_valid = 1; cif.load_value = 4'd15;
    tick(); cif.load_valid = 0;
    outs("l15", 15, 1, 0, 0);
    for (int i = 0; i < 60; i++) begin
      cif.enable     = (i % 3 != 0);
      cif.load_valid = (i % 5 == 0);
      cif.load_value = 4'(i % 16);
      cif.abort      = (i == 37);
      tick();
    end
    cif.load_valid = 0; cif.abort = 1; cif.enable = 1;
    tick(); cif.abort = 0;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    cif.reload = 1;
    cif.load_valid = 1; cif.load_value = 4'd2;
    tick(); cif.load_valid = 0;
    outs("ar 2", 2, 1, 0, 0);
    tick(); outs("ar 1", 1, 1, 0, 0);
    tick(); outs("ar 2 again", 2, 1, 0, 1);
    tick(); outs("ar 1 again", 1, 1, 0, 0);
    tick(); outs("ar 2 third", 2, 1, 0, 1);
    cif.reload = 0;
    tick(); outs("ar off 1", 1, 1, 0, 0);
    tick(); outs("ar off 0", 0, 0, 1, 1);
`endif

    tick();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, limit %0d", 100000);
    $fatal(1);
  end

endmodule

`default_nettype wire
